// File: rtl/mem_responder_if.sv
// Processor-side memory bus between the multicycle core (master) and the
// memory responder (slave).
interface mem_responder_if;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemFault;
  logic        Busy;

  modport master (output MemReq, MemWrite, Adr, WriteData,
                  input  ReadData, MemReady, MemFault, Busy);
  modport slave  (input  MemReq, MemWrite, Adr, WriteData,
                  output ReadData, MemReady, MemFault, Busy);
endinterface

// File: rtl/mem_responder.sv
// Unified I/D memory responder with programmable wait states, a one-cycle
// MemReady pulse and fault flagging for misaligned / out-of-range accesses.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2,
  parameter int CW          = 4
) (
  input logic             clk,
  input logic             reset,
  mem_responder_if.slave  bus
);
  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   adr_q, wdata_q, rdata;
  logic          we_q, fault_q, ready, fault;

  reg [31:0] mem [0:DEPTH-1];

  // With zero wait states the commit happens on the accepting edge, so the
  // commit source is the live bus in IDLE and the latched request otherwise.
  logic [31:0]   c_adr, c_wdata;
  logic          c_we, c_fault, go_resp;
  logic [IW-1:0] c_idx;

  always_comb begin
    c_adr   = adr_q;
    c_wdata = wdata_q;
    c_we    = we_q;
    c_fault = fault_q;
    if (state == S_IDLE) begin
      c_adr   = bus.Adr;
      c_wdata = bus.WriteData;
      c_we    = bus.MemWrite;
      c_fault = (bus.Adr[1:0] != 2'b00) || (bus.Adr[31:2] >= DEPTH_W);
    end
    c_idx   = c_adr[IW+1:2];
    go_resp = ((state == S_IDLE) && bus.MemReq && (WAIT_STATES == 0)) ||
              ((state == S_WAIT) && (cnt == CW'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      rdata   <= '0;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      ready <= 1'b0;
      fault <= 1'b0;
      case (state)
        S_IDLE: if (bus.MemReq) begin
          adr_q   <= c_adr;
          wdata_q <= c_wdata;
          we_q    <= c_we;
          fault_q <= c_fault;
          cnt     <= CW'(WAIT_STATES);
          state   <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (go_resp) begin
        ready <= 1'b1;
        fault <= c_fault;
        rdata <= (c_we || c_fault) ? 32'h0 : mem[c_idx];
      end
    end
  end

  // Array has no reset; a reset edge also suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (!reset && go_resp && c_we && !c_fault) mem[c_idx] <= c_wdata;
  end

  assign bus.ReadData = rdata;
  assign bus.MemReady = ready;
  assign bus.MemFault = fault;
  assign bus.Busy     = (state != S_IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: WAIT_STATES=2 instance driven from a vector table plus
// hand sequences, and a WAIT_STATES=0 instance for back-to-back traffic.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if bus2();
  mem_responder_if bus0();

  mem_responder #(.DEPTH(64), .WAIT_STATES(2), .CW(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
  mem_responder #(.DEPTH(64), .WAIT_STATES(0), .CW(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_fault;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(bit we, logic [31:0] adr, logic [31:0] wd,
                              logic [31:0] rd, bit f);
    vec_t v;
    v.we = we; v.adr = adr; v.wd = wd; v.exp_rd = rd; v.exp_fault = f;
    return v;
  endfunction

  // One request on the 2-wait-state DUT: acceptance at edge T, Busy for three
  // cycles, MemReady visible only in the third cycle after T.
  task automatic apply2(input vec_t v, input int idx);
    @(negedge clk);
    bus2.MemReq = 1'b1; bus2.MemWrite = v.we; bus2.Adr = v.adr; bus2.WriteData = v.wd;
    @(posedge clk);
    #1;
    bus2.MemReq = 1'b0; bus2.MemWrite = ~v.we;
    bus2.Adr = 32'hBAD0_BAD0; bus2.WriteData = 32'h5555_AAAA;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d busy c%0d", idx, k), {31'b0, bus2.Busy}, 32'd1);
      chk($sformatf("v%0d ready c%0d", idx, k), {31'b0, bus2.MemReady}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) begin
        chk($sformatf("v%0d fault", idx), {31'b0, bus2.MemFault}, {31'b0, v.exp_fault});
        chk($sformatf("v%0d rdata", idx), bus2.ReadData, v.exp_rd);
      end else begin
        chk($sformatf("v%0d fault-idle c%0d", idx, k), {31'b0, bus2.MemFault}, 32'd0);
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d ready-after", idx), {31'b0, bus2.MemReady}, 32'd0);
    chk($sformatf("v%0d busy-after", idx), {31'b0, bus2.Busy}, 32'd0);
  endtask

  int nready;

  initial begin
    bus2.MemReq = 0; bus2.MemWrite = 0; bus2.Adr = 0; bus2.WriteData = 0;
    bus0.MemReq = 0; bus0.MemWrite = 0; bus0.Adr = 0; bus0.WriteData = 0;

    tbl[0]  = mk(1, 32'h10,       32'hDEADBEEF, 32'h0,        0);
    tbl[1]  = mk(1, 32'h14,       32'h12345678, 32'h0,        0);
    tbl[2]  = mk(0, 32'h10,       32'h0,        32'hDEADBEEF, 0);
    tbl[3]  = mk(0, 32'h14,       32'h0,        32'h12345678, 0);
    tbl[4]  = mk(1, 32'h11,       32'h99999999, 32'h0,        1);
    tbl[5]  = mk(0, 32'h100,      32'h0,        32'h0,        1);
    tbl[6]  = mk(0, 32'hFFFFFFFC, 32'h0,        32'h0,        1);
    tbl[7]  = mk(0, 32'h10,       32'h0,        32'hDEADBEEF, 0);
    tbl[8]  = mk(1, 32'hFC,       32'hA5A5A5A5, 32'h0,        0);
    tbl[9]  = mk(0, 32'hFC,       32'h0,        32'hA5A5A5A5, 0);
    tbl[10] = mk(0, 32'h12,       32'h0,        32'h0,        1);
    tbl[11] = mk(1, 32'h20,       32'h11111111, 32'h0,        0);
    tbl[12] = mk(0, 32'h20,       32'h0,        32'h11111111, 0);
    tbl[13] = mk(1, 32'h13C,      32'h77777777, 32'h0,        1);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", {31'b0, bus2.MemReady}, 32'd0);
    chk("rst fault", {31'b0, bus2.MemFault}, 32'd0);
    chk("rst rdata", bus2.ReadData, 32'd0);
    chk("rst busy",  {31'b0, bus2.Busy}, 32'd0);
    chk("rst0 busy", {31'b0, bus0.Busy}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) apply2(tbl[i], i);

    // MemReq held high: second request (Adr changed mid-WAIT) accepted 4 cycles later
    @(negedge clk);
    bus2.MemReq = 1; bus2.MemWrite = 0; bus2.Adr = 32'h10;
    @(posedge clk);
    nready = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 2) bus2.Adr = 32'h14;
      if (k == 5) bus2.MemReq = 0;
      if (bus2.MemReady) nready++;
      chk($sformatf("hold ready c%0d", k), {31'b0, bus2.MemReady}, (k == 3 || k == 7) ? 32'd1 : 32'd0);
      if (k == 3) chk("hold rdata1", bus2.ReadData, 32'hDEADBEEF);
      if (k == 7) chk("hold rdata2", bus2.ReadData, 32'h12345678);
    end
    chk("hold ready count", nready, 32'd2);

    // reset during WAIT of a write discards it
    @(negedge clk);
    bus2.MemReq = 1; bus2.MemWrite = 1; bus2.Adr = 32'h20; bus2.WriteData = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus2.MemReq = 0;
    @(negedge clk);
    chk("rstw busy", {31'b0, bus2.Busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstw idle", {31'b0, bus2.Busy}, 32'd0);
    nready = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus2.MemReady) nready++;
    end
    chk("rstw no ready", nready, 32'd0);
    apply2(tbl[12], 99);

    // zero-wait-state instance: continuous requests every 2 cycles
    @(negedge clk);
    bus0.MemReq = 1; bus0.MemWrite = 1; bus0.Adr = 32'h8; bus0.WriteData = 32'h00000077;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("ws0 ready c%0d", k), {31'b0, bus0.MemReady}, (k % 2 == 1 && k <= 5) ? 32'd1 : 32'd0);
      case (k)
        1: begin
          chk("ws0 wr fault", {31'b0, bus0.MemFault}, 32'd0);
          chk("ws0 busy", {31'b0, bus0.Busy}, 32'd1);
          bus0.MemWrite = 0; bus0.Adr = 32'h8;
        end
        3: begin
          chk("ws0 rd data", bus0.ReadData, 32'h00000077);
          chk("ws0 rd fault", {31'b0, bus0.MemFault}, 32'd0);
          bus0.Adr = 32'h3;
        end
        5: begin
          chk("ws0 bad fault", {31'b0, bus0.MemFault}, 32'd1);
          chk("ws0 bad data", bus0.ReadData, 32'h0);
          bus0.MemReq = 0;
        end
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
